// File: rtl/nes_mmc1_mapper.sv
// MMC1 (iNES mapper 1): serial 5-bit register port, switchable PRG/CHR banking, software mirroring.
// Optional MMC1_WRAM_EN: drive o_sram_wp from the PRG register WRAM-disable bit.
module nes_mmc1_mapper #(
    parameter int unsigned PRG_BANK_W = 4,
    parameter int unsigned CHR_BANK_W = 5,
    parameter int unsigned FL_AW      = 23
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic [15:0]                    i_bus_addr,
    input  logic [7:0]                     i_bus_wdata,
    input  logic                           i_bus_r_wn,
    output logic [7:0]                     o_mmc_rdata,
    input  logic [FL_AW-14-PRG_BANK_W-1:0] i_game_base,
    output logic [FL_AW-1:0]               o_fl_addr,
    input  logic [7:0]                     i_fl_rdata,
    input  logic                           i_ppu_addr12,
    output logic [CHR_BANK_W-1:0]          o_chr_bank,
    output logic                           o_sram_wp,
    output logic [2:0]                     o_mirror_mode,
    output logic                           o_irq_n
);

    localparam logic [4:0] CTRL_RST   = 5'h0C;
    localparam logic [4:0] SHIFT_MARK = 5'b10000;
    localparam logic [2:0] CNT_LOAD   = 3'd5;

    logic                  r_wr_d;
    logic [4:0]            r_shift;
    logic [2:0]            r_count;
    logic [1:0]            r_sel;
    logic [4:0]            r_ctrl;
    logic [CHR_BANK_W-1:0] r_chr0;
    logic [CHR_BANK_W-1:0] r_chr1;
    logic [PRG_BANK_W-1:0] r_prg;
    logic                  r_prg_wd;
    logic [2:0]            r_mirror;

    logic                  w_wr_req;
    logic                  w_accept;
    logic [4:0]            w_shift_nxt;
    logic [2:0]            w_count_nxt;
    logic [1:0]            w_sel_nxt;
    logic [4:0]            w_ctrl_nxt;
    logic [CHR_BANK_W-1:0] w_chr0_nxt;
    logic [CHR_BANK_W-1:0] w_chr1_nxt;
    logic [PRG_BANK_W-1:0] w_prg_nxt;
    logic                  w_prg_wd_nxt;
    logic [2:0]            w_mirror_nxt;
    logic [PRG_BANK_W-1:0] w_prg_bank;

    // Only the first clock of a (possibly multi-clock) CPU write is accepted.
    assign w_wr_req = ~i_bus_r_wn & i_bus_addr[15];
    assign w_accept = w_wr_req & ~r_wr_d;

    // Serial port: a reset-bit write beats a pending 5th-bit load.
    always_comb begin
        w_shift_nxt  = r_shift;
        w_count_nxt  = r_count;
        w_sel_nxt    = r_sel;
        w_ctrl_nxt   = r_ctrl;
        w_chr0_nxt   = r_chr0;
        w_chr1_nxt   = r_chr1;
        w_prg_nxt    = r_prg;
        w_prg_wd_nxt = r_prg_wd;
        if (w_accept && i_bus_wdata[7]) begin
            w_shift_nxt = SHIFT_MARK;
            w_count_nxt = 3'd0;
            w_ctrl_nxt  = r_ctrl | CTRL_RST;
        end else if (r_count == CNT_LOAD) begin
            case (r_sel)
                2'd0: w_ctrl_nxt = r_shift;
                2'd1: w_chr0_nxt = CHR_BANK_W'(r_shift);
                2'd2: w_chr1_nxt = CHR_BANK_W'(r_shift);
                2'd3: begin
                    w_prg_nxt    = PRG_BANK_W'(r_shift);
                    w_prg_wd_nxt = r_shift[4];
                end
            endcase
            w_shift_nxt = 5'd0;
            w_count_nxt = 3'd0;
        end else if (w_accept) begin
            w_shift_nxt = {i_bus_wdata[0], r_shift[4:1]};
            w_count_nxt = r_count + 3'd1;
            if (r_count == 3'd4) begin
                w_sel_nxt = i_bus_addr[14:13];
            end
        end
    end

    always_comb begin
        w_mirror_nxt = 3'd2;
        case (w_ctrl_nxt[1:0])
            2'd0: w_mirror_nxt = 3'd2;
            2'd1: w_mirror_nxt = 3'd3;
            2'd2: w_mirror_nxt = 3'd1;
            2'd3: w_mirror_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_d   <= 1'b0;
            r_shift  <= 5'd0;
            r_count  <= 3'd0;
            r_sel    <= 2'd0;
            r_ctrl   <= CTRL_RST;
            r_chr0   <= '0;
            r_chr1   <= '0;
            r_prg    <= '0;
            r_prg_wd <= 1'b0;
            r_mirror <= 3'd2;
        end else begin
            r_wr_d   <= w_wr_req;
            r_shift  <= w_shift_nxt;
            r_count  <= w_count_nxt;
            r_sel    <= w_sel_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_chr0   <= w_chr0_nxt;
            r_chr1   <= w_chr1_nxt;
            r_prg    <= w_prg_nxt;
            r_prg_wd <= w_prg_wd_nxt;
            r_mirror <= w_mirror_nxt;
        end
    end

    // PRG banking: 32K, fixed-low, or fixed-high (last bank) modes.
    always_comb begin
        w_prg_bank = {r_prg[PRG_BANK_W-1:1], i_bus_addr[14]};
        case (r_ctrl[3:2])
            2'd2:    w_prg_bank = i_bus_addr[14] ? r_prg : '0;
            2'd3:    w_prg_bank = i_bus_addr[14] ? '1 : r_prg;
            default: w_prg_bank = {r_prg[PRG_BANK_W-1:1], i_bus_addr[14]};
        endcase
    end

    assign o_fl_addr     = i_bus_addr[15] ? {i_game_base, w_prg_bank, i_bus_addr[13:0]} : '0;
    assign o_mmc_rdata   = i_bus_addr[15] ? i_fl_rdata : 8'd0;
    assign o_chr_bank    = r_ctrl[4] ? (i_ppu_addr12 ? r_chr1 : r_chr0)
                                     : {r_chr0[CHR_BANK_W-1:1], i_ppu_addr12};
    assign o_mirror_mode = r_mirror;
    assign o_irq_n       = 1'b1;

`ifdef MMC1_WRAM_EN
    logic r_sram_wp;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sram_wp <= 1'b0;
        end else begin
            r_sram_wp <= w_prg_wd_nxt;
        end
    end

    assign o_sram_wp = r_sram_wp;

    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, i_bus_wdata[6:1]};
`else
    assign o_sram_wp = 1'b0;

    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, i_bus_wdata[6:1], r_prg_wd};
`endif

endmodule

// File: tb/tb_nes_mmc1_mapper.sv
// Directed bench for nes_mmc1_mapper: serial register programming, banking modes, reset behaviour.
module tb_nes_mmc1_mapper;

    logic        clk;
    logic        rstn;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_r_wn;
    logic [7:0]  mmc_rdata;
    logic [4:0]  game_base;
    logic [22:0] fl_addr;
    logic [7:0]  fl_rdata;
    logic        ppu_addr12;
    logic [4:0]  chr_bank;
    logic        sram_wp;
    logic [2:0]  mirror_mode;
    logic        irq_n;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [4:0] BASE = 5'h13;

    nes_mmc1_mapper #(.PRG_BANK_W(4), .CHR_BANK_W(5), .FL_AW(23)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_bus_addr   (bus_addr),
        .i_bus_wdata  (bus_wdata),
        .i_bus_r_wn   (bus_r_wn),
        .o_mmc_rdata  (mmc_rdata),
        .i_game_base  (game_base),
        .o_fl_addr    (fl_addr),
        .i_fl_rdata   (fl_rdata),
        .i_ppu_addr12 (ppu_addr12),
        .o_chr_bank   (chr_bank),
        .o_sram_wp    (sram_wp),
        .o_mirror_mode(mirror_mode),
        .o_irq_n      (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU write held low for 'hold' clocks, then released for one clock.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        bus_addr  = a;
        bus_wdata = d;
        bus_r_wn  = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        bus_r_wn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic ser(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr(a, {7'd0, v[i]}, 1);
    endtask

    task automatic rd(input logic [15:0] a);
        bus_addr = a;
        bus_r_wn = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] fa(input logic [3:0] bank, input logic [13:0] off);
        return 32'({BASE, bank, off});
    endfunction

    initial begin
        rstn       = 1'b0;
        bus_addr   = 16'h0000;
        bus_wdata  = 8'h00;
        bus_r_wn   = 1'b1;
        game_base  = BASE;
        fl_rdata   = 8'hA5;
        ppu_addr12 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mirror", 32'(mirror_mode), 32'd2);
        chk("rst_chr", 32'(chr_bank), 32'd0);
        chk("rst_fl_addr_low", 32'(fl_addr), 32'd0);
        chk("rst_rdata_low", 32'(mmc_rdata), 32'd0);
        chk("rst_irq_n", 32'(irq_n), 32'd1);
        chk("rst_sram_wp", 32'(sram_wp), 32'd0);
        rstn = 1'b1;

        rd(16'hFFFC);
        chk("rst_fffc", 32'(fl_addr), fa(4'hF, 14'h3FFC));
        chk("rdata_hi", 32'(mmc_rdata), 32'hA5);

        ser(16'h8000, 5'b01110);
        chk("ctrl0e_mirror", 32'(mirror_mode), 32'd1);

        ser(16'hE000, 5'd5);
        rd(16'h8123);
        chk("m3_8123", 32'(fl_addr), fa(4'h5, 14'h0123));
        rd(16'hC000);
        chk("m3_c000", 32'(fl_addr), fa(4'hF, 14'h0000));

        ser(16'h8000, 5'b01011);
        chk("ctrl0b_mirror", 32'(mirror_mode), 32'd0);
        rd(16'h8000);
        chk("m2_8000", 32'(fl_addr), fa(4'h0, 14'h0000));
        rd(16'hC456);
        chk("m2_c456", 32'(fl_addr), fa(4'h5, 14'h0456));

        ser(16'h8000, 5'b00001);
        chk("ctrl01_mirror", 32'(mirror_mode), 32'd3);
        rd(16'h8000);
        chk("m0_8000", 32'(fl_addr), fa(4'h4, 14'h0000));
        rd(16'hC000);
        chk("m0_c000", 32'(fl_addr), fa(4'h5, 14'h0000));

        ser(16'hA000, 5'd7);
        ppu_addr12 = 1'b0;
        #1;
        chk("chr8k_lo", 32'(chr_bank), 32'd6);
        ppu_addr12 = 1'b1;
        #1;
        chk("chr8k_hi", 32'(chr_bank), 32'd7);

        // Abort a partial sequence with a reset-bit write.
        for (int i = 0; i < 3; i++) wr(16'h8000, 8'h01, 1);
        wr(16'h8000, 8'h80, 1);
        chk("abort_mirror", 32'(mirror_mode), 32'd3);
        rd(16'h8000);
        chk("abort_m3_8000", 32'(fl_addr), fa(4'h5, 14'h0000));
        ser(16'h8000, 5'b10010);
        chk("after_abort_mirror", 32'(mirror_mode), 32'd1);
        rd(16'hC000);
        chk("after_abort_c000", 32'(fl_addr), fa(4'h5, 14'h0000));

        ser(16'hA000, 5'd3);
        ser(16'hC000, 5'd9);
        ppu_addr12 = 1'b0;
        #1;
        chk("chr4k_lo", 32'(chr_bank), 32'd3);
        ppu_addr12 = 1'b1;
        #1;
        chk("chr4k_hi", 32'(chr_bank), 32'd9);

        // First bit held for 4 clocks must shift only once.
        wr(16'h8000, 8'h01, 4);
        wr(16'h8000, 8'h01, 1);
        wr(16'h8000, 8'h00, 1);
        wr(16'h8000, 8'h01, 1);
        wr(16'h8000, 8'h01, 1);
        chk("hold_mirror", 32'(mirror_mode), 32'd0);
        rd(16'h8000);
        chk("hold_m2_8000", 32'(fl_addr), fa(4'h0, 14'h0000));

        ser(16'hE000, 5'h10);
`ifdef MMC1_WRAM_EN
        chk("sram_wp_set", 32'(sram_wp), 32'd1);
`else
        chk("sram_wp_const", 32'(sram_wp), 32'd0);
`endif

        // Asynchronous reset in the middle of a serial sequence.
        wr(16'h8000, 8'h01, 1);
        wr(16'h8000, 8'h01, 1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_mirror", 32'(mirror_mode), 32'd2);
        chk("async_sram_wp", 32'(sram_wp), 32'd0);
        ppu_addr12 = 1'b0;
        rd(16'hFFFC);
        chk("async_fffc", 32'(fl_addr), fa(4'hF, 14'h3FFC));
        chk("async_chr", 32'(chr_bank), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ser(16'h8000, 5'b00010);
        chk("post_rst_mirror", 32'(mirror_mode), 32'd1);
        rd(16'hC000);
        chk("post_rst_c000", 32'(fl_addr), fa(4'h1, 14'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
